// File: rtl/kyber_pkg.sv
// Shared constants and FSM encoding for the Kyber public-key byte unpacker.
// UNPACK_SEED_EN adds the SEED state for rho forwarding.
package kyber_pkg;

    localparam int unsigned KYBER_N         = 256;
    localparam int unsigned POLY_T_BYTES    = 320;
    localparam int unsigned GROUP_BYTES     = 5;
    localparam int unsigned SEED_BYTES      = 32;
    localparam int unsigned GROUPS_PER_POLY = POLY_T_BYTES / GROUP_BYTES;
    localparam int unsigned GROUP_W         = GROUP_BYTES * 8;
    localparam int unsigned BYTE_CNT_W      = 3;
    localparam int unsigned GRP_IDX_W       = 8;
    localparam int unsigned SEED_CNT_W      = $clog2(SEED_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POLY = 2'd1,
`ifdef UNPACK_SEED_EN
        SEED = 2'd2,
`endif
        DONE = 2'd3
    } unpack_state_e;

    typedef logic [GROUP_W-1:0] group_t;

endpackage

// File: rtl/pk_byte_unpacker_if.sv
// Byte-in / group-out bus of the public-key unpacker, plus start/busy/done.
// Seed forwarding signals exist only under UNPACK_SEED_EN.
interface pk_byte_unpacker_if import kyber_pkg::*; ();

    logic                 start;
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    group_t               a;
    logic                 a_valid;
    logic                 a_ready;
    logic [GRP_IDX_W-1:0] grp_idx;
`ifdef UNPACK_SEED_EN
    logic [7:0]           seed_data;
    logic                 seed_valid;
`endif
    logic                 busy;
    logic                 done;

    modport master (
        input  start, in_data, in_valid, a_ready,
`ifdef UNPACK_SEED_EN
        output seed_data, seed_valid,
`endif
        output in_ready, a, a_valid, grp_idx, busy, done
    );

    modport slave (
        output start, in_data, in_valid, a_ready,
`ifdef UNPACK_SEED_EN
        input  seed_data, seed_valid,
`endif
        input  in_ready, a, a_valid, grp_idx, busy, done
    );

endinterface

// File: rtl/pk_byte_unpacker_group_shifter.sv
// byte_group_shifter: collects 5 bytes into one 40-bit group, oldest byte in the MSBs.
// Only four bytes are stored; the fifth joins combinationally so the group loads on its own edge.
module byte_group_shifter import kyber_pkg::*; (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_shift,
    input  logic [7:0] i_byte,
    output group_t     o_group_c,
    output logic       o_grp_done_c
);

    logic [GROUP_W-9:0]    r_sr;
    logic [BYTE_CNT_W-1:0] r_cnt;
    logic                  w_last;

    assign w_last       = (r_cnt == BYTE_CNT_W'(GROUP_BYTES - 1));
    assign o_grp_done_c = i_shift && w_last;
    assign o_group_c    = {r_sr, i_byte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_sr  <= {r_sr[GROUP_W-17:0], i_byte};
            r_cnt <= w_last ? '0 : r_cnt + BYTE_CNT_W'(1);
        end
    end

endmodule

// File: rtl/pk_byte_unpacker.sv
// Kyber public-key unpacker: splits the byte stream into 5-byte t groups with a
// valid/ready output stage; UNPACK_SEED_EN forwards the trailing 32 rho bytes.
module pk_byte_unpacker import kyber_pkg::*; #(
    parameter int unsigned KYBER_K = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pk_byte_unpacker_if.master   bus
);

    localparam int unsigned          N_GROUPS = GROUPS_PER_POLY * KYBER_K;
    localparam logic [GRP_IDX_W-1:0] LAST_IDX = GRP_IDX_W'(N_GROUPS - 1);

    unpack_state_e        r_state;
    unpack_state_e        w_state_nxt;
    group_t               r_a;
    group_t               w_group;
    logic                 r_a_valid;
    logic [GRP_IDX_W-1:0] r_grp_idx;
    logic [GRP_IDX_W-1:0] w_idx_inc;
    logic [GRP_IDX_W-1:0] w_load_idx;
    logic                 r_all_in;
    logic                 w_in_ready;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_clr;
    logic                 w_accept;
    logic                 w_poly_shift;
    logic                 w_grp_done;
    logic                 w_a_take;
`ifdef UNPACK_SEED_EN
    logic [7:0]            r_seed_data;
    logic                  r_seed_valid;
    logic [SEED_CNT_W-1:0] r_seed_cnt;
    logic                  w_seed_acc;
`endif

    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_poly_shift = w_accept && (r_state == POLY);
    assign w_a_take     = r_a_valid && bus.a_ready;
    assign w_idx_inc    = (r_grp_idx == LAST_IDX) ? '0 : r_grp_idx + GRP_IDX_W'(1);
    // Index the completing group will carry once it reaches the output register.
    assign w_load_idx   = r_a_valid ? w_idx_inc : r_grp_idx;

    byte_group_shifter u_shifter (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_clr),
        .i_shift      (w_poly_shift),
        .i_byte       (bus.in_data),
        .o_group_c    (w_group),
        .o_grp_done_c (w_grp_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (bus.start) w_state_nxt = POLY;
            POLY: begin
                if (w_a_take && (r_grp_idx == LAST_IDX)) begin
`ifdef UNPACK_SEED_EN
                    w_state_nxt = SEED;
`else
                    w_state_nxt = DONE;
`endif
                end
            end
`ifdef UNPACK_SEED_EN
            SEED: if (w_seed_acc && (r_seed_cnt == SEED_CNT_W'(SEED_BYTES - 1))) w_state_nxt = DONE;
`endif
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs; in POLY no byte is taken once the final group is loaded.
    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = (r_state != IDLE);
        w_done     = (r_state == DONE);
        w_clr      = (r_state == IDLE) && bus.start;
        case (r_state)
            POLY:    w_in_ready = !(r_a_valid && !bus.a_ready) && !r_all_in;
`ifdef UNPACK_SEED_EN
            SEED:    w_in_ready = 1'b1;
`endif
            default: w_in_ready = 1'b0;
        endcase
    end

    // Group output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_a_valid <= 1'b0;
            r_grp_idx <= '0;
            r_all_in  <= 1'b0;
        end else if (w_clr) begin
            r_a_valid <= 1'b0;
            r_grp_idx <= '0;
            r_all_in  <= 1'b0;
        end else begin
            if (w_a_take) r_grp_idx <= w_idx_inc;
            if (w_grp_done) begin
                r_a       <= w_group;
                r_a_valid <= 1'b1;
                if (w_load_idx == LAST_IDX) r_all_in <= 1'b1;
            end else if (w_a_take) begin
                r_a_valid <= 1'b0;
            end
        end
    end

`ifdef UNPACK_SEED_EN
    assign w_seed_acc = w_accept && (r_state == SEED);

    // Seed pass-through, no backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seed_data  <= '0;
            r_seed_valid <= 1'b0;
            r_seed_cnt   <= '0;
        end else begin
            r_seed_valid <= w_seed_acc;
            if (w_seed_acc) r_seed_data <= bus.in_data;
            if (w_clr)           r_seed_cnt <= '0;
            else if (w_seed_acc) r_seed_cnt <= r_seed_cnt + SEED_CNT_W'(1);
        end
    end

    assign bus.seed_data  = r_seed_data;
    assign bus.seed_valid = r_seed_valid;
`endif

    assign bus.in_ready = w_in_ready;
    assign bus.a        = r_a;
    assign bus.a_valid  = r_a_valid;
    assign bus.grp_idx  = r_grp_idx;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;

endmodule

// File: tb/tb_pk_byte_unpacker.sv
// Directed bench for pk_byte_unpacker: group table, backpressure, reset, full-key runs.
// Build with UNPACK_SEED_EN defined to also exercise the rho forwarding path.
module tb_pk_byte_unpacker;
    import kyber_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pk_byte_unpacker_if bus();

    pk_byte_unpacker #(.KYBER_K(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [39:0] cap_a[$];
    logic [7:0]  cap_idx[$];
    logic [7:0]  seed_q[$];
    int          done_cnt     = 0;
    int          seed_at_done = 0;

    // Group/seed/done monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.a_valid && bus.a_ready) begin
                cap_a.push_back(bus.a);
                cap_idx.push_back(bus.grp_idx);
            end
`ifdef UNPACK_SEED_EN
            if (bus.seed_valid) seed_q.push_back(bus.seed_data);
`endif
            if (bus.done) begin
                done_cnt++;
                seed_at_done = seed_q.size();
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            n_checks++;
            $display("FAIL send_byte_timeout: in_ready 0 for 200 cycles, required 1");
        end
    endtask

    task automatic idle_cycle(input logic st);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.start    = st;
    endtask

    task automatic pulse_start();
        idle_cycle(1'b1);
        idle_cycle(1'b0);
    endtask

    function automatic logic [39:0] pat_group(input int g);
        logic [39:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) r = {r[31:0], 8'((5 * g + k) % 256)};
        return r;
    endfunction

    // One complete key: 640 t bytes (+32 rho bytes) of pattern i mod 256
    task automatic run_full(input bit toggle, input string tag);
        int g0, d0, s0, bad, t, n;
        g0 = cap_a.size(); d0 = done_cnt; s0 = seed_q.size(); bad = 0;
        pulse_start();
        for (int i = 0; i < 640; i++) begin
            send_byte(8'(i % 256));
            if (toggle) idle_cycle(i == 100);
        end
`ifdef UNPACK_SEED_EN
        for (int i = 640; i < 672; i++) send_byte(8'(i % 256));
`endif
        idle_cycle(1'b0);
        t = 0;
        while (done_cnt == d0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        n = cap_a.size() - g0;
        check({tag, "_groups"}, 64'(n), 64'd128);
        for (int g = 0; g < n && g < 128; g++)
            if (cap_a[g0+g] !== pat_group(g) || cap_idx[g0+g] !== 8'(g)) bad++;
        check({tag, "_pattern_errs"}, 64'(bad), 64'd0);
        check({tag, "_group1"}, (n > 1) ? 64'(cap_a[g0+1]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'h05_0607_0809);
        check({tag, "_last_idx"}, (n > 127) ? 64'(cap_idx[g0+127]) : 64'hFFFF, 64'd127);
        check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_in_ready_after"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
`ifdef UNPACK_SEED_EN
        check({tag, "_seed_pulses"}, 64'(seed_q.size() - s0), 64'd32);
        check({tag, "_seed_first"}, (seed_q.size() > s0) ? 64'(seed_q[s0]) : 64'hFFFF, 64'h80);
        check({tag, "_seed_last"}, (seed_q.size() > s0 + 31) ? 64'(seed_q[s0+31]) : 64'hFFFF, 64'h9F);
        check({tag, "_seed_before_done"}, 64'(seed_at_done - s0), 64'd32);
`endif
    endtask

    typedef struct {
        logic [39:0] bytes_in;
        int          hold;
        logic [39:0] exp_a;
        logic [7:0]  exp_idx;
    } vec_t;

    vec_t tbl[7];

    initial begin
        bit held;
        int c0;

        tbl[0] = '{40'h01_0203_0405,  0, 40'h01_0203_0405, 8'd0};
        tbl[1] = '{40'hA5_5AFF_0081, 10, 40'hA5_5AFF_0081, 8'd1};
        tbl[2] = '{40'h00_0000_0000,  0, 40'h00_0000_0000, 8'd2};
        tbl[3] = '{40'hFF_FFFF_FFFF,  3, 40'hFF_FFFF_FFFF, 8'd3};
        tbl[4] = '{40'h12_3456_789A,  0, 40'h12_3456_789A, 8'd4};
        tbl[5] = '{40'h80_0180_0180,  1, 40'h80_0180_0180, 8'd5};
        tbl[6] = '{40'hDE_ADBE_EF42,  0, 40'hDE_ADBE_EF42, 8'd6};

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.a_ready  = 1'b1;

        #12;
        check("rst_a",        64'(bus.a),        64'd0);
        check("rst_a_valid",  64'(bus.a_valid),  64'd0);
        check("rst_grp_idx",  64'(bus.grp_idx),  64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_busy",     64'(bus.busy),     64'd0);
        check("rst_done",     64'(bus.done),     64'd0);
`ifdef UNPACK_SEED_EN
        check("rst_seed_data",  64'(bus.seed_data),  64'd0);
        check("rst_seed_valid", 64'(bus.seed_valid), 64'd0);
`endif
        @(negedge clk); rst_n = 1'b1;

        // Table: one group per entry, optional a_ready stall after it loads
        pulse_start();
        c0 = cap_a.size();
        for (int v = 0; v < 7; v++) begin
            @(posedge clk); #1;
            bus.a_ready = (tbl[v].hold == 0);
            for (int k = 0; k < 5; k++) send_byte(tbl[v].bytes_in[39-8*k -: 8]);
            idle_cycle(1'b0);
            @(negedge clk);
            check($sformatf("vec%0d_a", v),       64'(bus.a),       64'(tbl[v].exp_a));
            check($sformatf("vec%0d_idx", v),     64'(bus.grp_idx), 64'(tbl[v].exp_idx));
            check($sformatf("vec%0d_a_valid", v), 64'(bus.a_valid), 64'd1);
            if (tbl[v].hold > 0) begin
                held = 1'b1;
                for (int c = 0; c < tbl[v].hold; c++) begin
                    @(negedge clk);
                    if (!(bus.a_valid && !bus.in_ready && bus.a === tbl[v].exp_a &&
                          bus.grp_idx === tbl[v].exp_idx)) held = 1'b0;
                end
                check($sformatf("vec%0d_held_stable", v), 64'(held), 64'd1);
                @(posedge clk); #1;
                bus.a_ready = 1'b1;
                @(negedge clk);
            end
            @(negedge clk);
            check($sformatf("vec%0d_a_valid_drop", v), 64'(bus.a_valid), 64'd0);
        end
        check("tbl_groups_seen", 64'(cap_a.size() - c0), 64'd7);

        // Reset in the middle of group 7, then a fresh start must begin at index 0
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        idle_cycle(1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_a",        64'(bus.a),        64'd0);
        check("midrst_a_valid",  64'(bus.a_valid),  64'd0);
        check("midrst_grp_idx",  64'(bus.grp_idx),  64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        check("midrst_busy",     64'(bus.busy),     64'd0);
        check("midrst_done",     64'(bus.done),     64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        held = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.in_ready || bus.busy) held = 1'b0;
        end
        check("idle_refuses_bytes", 64'(held), 64'd1);
        idle_cycle(1'b0);
        pulse_start();
        for (int k = 0; k < 5; k++) send_byte(8'(8'hC1 + k));
        idle_cycle(1'b0);
        @(negedge clk);
        check("postrst_a",       64'(bus.a),       64'hC1_C2C3_C4C5);
        check("postrst_grp_idx", 64'(bus.grp_idx), 64'd0);
        check("postrst_a_valid", 64'(bus.a_valid), 64'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        run_full(1'b0, "full");
        run_full(1'b1, "toggle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
